brick_field: RTL

Brick-field manager for the 640x480 breakout datapath. Holds the alive state of the 15 bricks (3 rows x 5 columns) and tests the ball rectangle against every live brick. Emits one-cycle per-brick collision pulses plus the struck brick's geometry to the ball stage, and asserts `win` once the field is cleared. Also renders the brick layer of the pixel stream for the top-level colour mux.

---
 rtl/brick_field_pkg.sv | 40 ++++
 rtl/brick_field_if.sv | 34 +++
 rtl/brick_hit_test.sv | 49 ++++
 rtl/brick_field.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/brick_field_pkg.sv
// ---------------------------------------------------------------------------
// brick_field_pkg
// Shared definitions for the breakout brick field: default brick geometry,
// field dimensions, row colours and the field FSM state encoding.
// ---------------------------------------------------------------------------
package brick_field_pkg;

  // Default brick geometry (pixels, 640x480 screen)
  localparam int DEF_BLK_W   = 120;
  localparam int DEF_BLK_H   = 40;
  localparam int DEF_X0      = 4;
  localparam int DEF_Y0      = 40;
  localparam int DEF_PITCH_X = 128;
  localparam int DEF_PITCH_Y = 48;

  // Field dimensions
  localparam int N_ROWS   = 3;
  localparam int N_COLS   = 5;
  localparam int N_BLOCKS = N_ROWS * N_COLS;

  // Row colours, 24-bit RGB
  localparam logic [23:0] ROW0_COLOR = 24'hff0000;
  localparam logic [23:0] ROW1_COLOR = 24'hffa500;
  localparam logic [23:0] ROW2_COLOR = 24'h00ff00;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WON  = 2'd1,
    ST_LOST = 2'd2
  } state_e;

  function automatic logic [23:0] row_color(input int row);
    case (row)
      0:       row_color = ROW0_COLOR;
      1:       row_color = ROW1_COLOR;
      default: row_color = ROW2_COLOR;
    endcase
  endfunction

endpackage

// File: rtl/brick_field_if.sv
// ---------------------------------------------------------------------------
// brick_field_if
// Link between the ball stage and the brick field.
//   ball_x/ball_y/ball_width/ball_height : ball rectangle (ball -> field)
//   lose                                 : loss flag      (ball -> field)
//   collide_block                        : one-hot hit pulse (field -> ball)
//   block_x/block_y                      : origin of last-struck brick
//   block_width/block_height             : brick size (constants)
// master = ball stage side, slave = brick field side.
// ---------------------------------------------------------------------------
interface brick_field_if;
  import brick_field_pkg::*;

  logic [9:0]          ball_x;
  logic [9:0]          ball_y;
  logic [9:0]          ball_width;
  logic [9:0]          ball_height;
  logic                lose;
  logic [N_BLOCKS-1:0] collide_block;
  logic [9:0]          block_x;
  logic [9:0]          block_y;
  logic [9:0]          block_width;
  logic [9:0]          block_height;

  modport master (
    output ball_x, ball_y, ball_width, ball_height, lose,
    input  collide_block, block_x, block_y, block_width, block_height
  );

  modport slave (
    input  ball_x, ball_y, ball_width, ball_height, lose,
    output collide_block, block_x, block_y, block_width, block_height
  );
endinterface

// File: rtl/brick_hit_test.sv
// ---------------------------------------------------------------------------
// brick_hit_test
// Geometry test for one brick at a fixed origin (BX,BY).
//   ball_*  : ball rectangle
//   x, y    : current scan pixel
//   overlap : ball rectangle intersects the brick
//   pix_in  : scan pixel lies inside the brick
// All arithmetic is 11 bits wide so x+width cannot wrap.
// ---------------------------------------------------------------------------
module brick_hit_test
  import brick_field_pkg::*;
#(
  parameter int BX    = DEF_X0,
  parameter int BY    = DEF_Y0,
  parameter int BLK_W = DEF_BLK_W,
  parameter int BLK_H = DEF_BLK_H
) (
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] ball_width,
  input  logic [9:0] ball_height,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       overlap,
  output logic       pix_in
);

  localparam logic [10:0] LEFT   = 11'(BX);
  localparam logic [10:0] RIGHT  = 11'(BX + BLK_W);
  localparam logic [10:0] TOP    = 11'(BY);
  localparam logic [10:0] BOTTOM = 11'(BY + BLK_H);

  logic [10:0] ball_l, ball_r, ball_t, ball_b;
  logic [10:0] px, py;

  assign ball_l = {1'b0, ball_x};
  assign ball_r = {1'b0, ball_x} + {1'b0, ball_width};
  assign ball_t = {1'b0, ball_y};
  assign ball_b = {1'b0, ball_y} + {1'b0, ball_height};
  assign px     = {1'b0, x};
  assign py     = {1'b0, y};

  assign overlap = (ball_l < RIGHT) && (ball_r > LEFT) &&
                   (ball_t < BOTTOM) && (ball_b > TOP);

  assign pix_in  = (px >= LEFT) && (px < RIGHT) &&
                   (py >= TOP)  && (py < BOTTOM);

endmodule

// File: rtl/brick_field.sv
// ---------------------------------------------------------------------------
// brick_field
// Holds the alive state of the 3x5 brick field, tests the ball against every
// live brick, kills at most one brick per cycle (lowest index first), and
// renders the brick layer of the pixel stream.
//   clk, rst      : pixel clock, asynchronous active-low reset
//   x, y          : current scan pixel
//   active_pixels : visible-region qualifier
//   ball          : ball-stage link (rect + lose in, hit pulse + geometry out)
//   win           : field cleared (sticky until reset)
//   score         : bricks destroyed, 0..15
//   vga_color     : brick-layer colour, combinational
// ---------------------------------------------------------------------------
module brick_field
  import brick_field_pkg::*;
#(
  parameter int BLK_W   = DEF_BLK_W,
  parameter int BLK_H   = DEF_BLK_H,
  parameter int X0      = DEF_X0,
  parameter int Y0      = DEF_Y0,
  parameter int PITCH_X = DEF_PITCH_X,
  parameter int PITCH_Y = DEF_PITCH_Y
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               active_pixels,
  brick_field_if.slave       ball,
  output logic               win,
  output logic [3:0]         score,
  output logic [23:0]        vga_color
);

  logic [N_BLOCKS-1:0] overlap;
  logic [N_BLOCKS-1:0] pix_in;
  logic [9:0]          org_x [N_BLOCKS];
  logic [9:0]          org_y [N_BLOCKS];

  // Per-brick geometry; origins are elaboration-time constants.
  for (genvar i = 0; i < N_BLOCKS; i++) begin : g_brick
    localparam int BX = X0 + (i % N_COLS) * PITCH_X;
    localparam int BY = Y0 + (i / N_COLS) * PITCH_Y;

    assign org_x[i] = 10'(BX);
    assign org_y[i] = 10'(BY);

    brick_hit_test #(
      .BX    (BX),
      .BY    (BY),
      .BLK_W (BLK_W),
      .BLK_H (BLK_H)
    ) u_hit (
      .ball_x      (ball.ball_x),
      .ball_y      (ball.ball_y),
      .ball_width  (ball.ball_width),
      .ball_height (ball.ball_height),
      .x           (x),
      .y           (y),
      .overlap     (overlap[i]),
      .pix_in      (pix_in[i])
    );
  end

  state_e              state_q, state_d;
  logic [N_BLOCKS-1:0] alive_q, alive_d;
  logic [N_BLOCKS-1:0] collide_q, collide_d;
  logic [9:0]          block_x_q, block_x_d;
  logic [9:0]          block_y_q, block_y_d;
  logic [3:0]          score_q, score_d;
  logic                win_q, win_d;
  // A kill that coincides with lose is completed first; LOST follows next cycle.
  logic                lose_pend_q, lose_pend_d;

  logic [N_BLOCKS-1:0] hits;
  logic                kill_valid;
  logic [3:0]          kill_idx;

  assign hits       = overlap & alive_q;
  assign kill_valid = |hits;

  // Priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    kill_idx = '0;
    for (int i = N_BLOCKS - 1; i >= 0; i--) begin
      if (hits[i]) kill_idx = 4'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    alive_d     = alive_q;
    collide_d   = '0;
    block_x_d   = block_x_q;
    block_y_d   = block_y_q;
    score_d     = score_q;
    win_d       = win_q;
    lose_pend_d = lose_pend_q;

    unique case (state_q)
      ST_PLAY: begin
        if (lose_pend_q) begin
          state_d = ST_LOST;
        end else if (kill_valid) begin
          collide_d = N_BLOCKS'(1) << kill_idx;
          alive_d   = alive_q & ~collide_d;
          block_x_d = org_x[kill_idx];
          block_y_d = org_y[kill_idx];
          score_d   = score_q + 4'd1;
          if (alive_d == '0) begin
            state_d = ST_WON;
            win_d   = 1'b1;
          end else if (ball.lose) begin
            lose_pend_d = 1'b1;
          end
        end else if (ball.lose) begin
          state_d = ST_LOST;
        end
      end
      // WON and LOST are terminal: nothing evaluated, everything frozen.
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the alive vector is ordinary flops, not a memory, so it is reset
    // like any other state and reset restores the full field.
    if (!rst) begin
      state_q     <= ST_PLAY;
      alive_q     <= '1;
      collide_q   <= '0;
      block_x_q   <= 10'(X0);
      block_y_q   <= 10'(Y0);
      score_q     <= '0;
      win_q       <= 1'b0;
      lose_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      collide_q   <= collide_d;
      block_x_q   <= block_x_d;
      block_y_q   <= block_y_d;
      score_q     <= score_d;
      win_q       <= win_d;
      lose_pend_q <= lose_pend_d;
    end
  end

  assign ball.collide_block = collide_q;
  assign ball.block_x       = block_x_q;
  assign ball.block_y       = block_y_q;
  assign ball.block_width   = 10'(BLK_W);
  assign ball.block_height  = 10'(BLK_H);
  assign win                = win_q;
  assign score              = score_q;

  // Brick layer: bricks never overlap, so at most one term is live.
  always_comb begin
    vga_color = '0;
    if (active_pixels) begin
      for (int i = N_BLOCKS - 1; i >= 0; i--) begin
        if (pix_in[i] && alive_q[i]) vga_color = row_color(i / N_COLS);
      end
    end
  end

endmodule
